// File: rtl/transparency_fade_controller.sv
// Frame-synchronous fade controller: ramps src_a_proportion one LSB at a time toward
// a commanded target, stepping only on frame_start so a blend never changes mid-frame.
module transparency_fade_controller #(
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int FRAME_DIV_WIDTH        = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_start,
  input  logic [TRANSPARENCY_PRECISION-1:0] target_proportion,
  input  logic [FRAME_DIV_WIDTH-1:0]        frames_per_step,
  input  logic                              jump,
  output logic [TRANSPARENCY_PRECISION-1:0] src_a_proportion,
  output logic                              fading,
  output logic                              fade_done
);

  localparam int P = TRANSPARENCY_PRECISION;
  localparam int W = FRAME_DIV_WIDTH;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [P-1:0]   prop_q, prop_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [W-1:0]   eff_fps_s;
  logic [W-1:0]   c_base_s;
  logic [W-1:0]   c_next_s;
  logic [P-1:0]   stepped_s;
  logic           dir_up_s;

  // Step arithmetic shared by the IDLE->FADING entry and the FADING counting rule
  always_comb begin
    if (frames_per_step == {W{1'b0}}) begin
      eff_fps_s = W'(1);
    end else begin
      eff_fps_s = frames_per_step;
    end

    // A fade entered from IDLE always counts from zero
    if (state_q == FADING) begin
      c_base_s = cnt_q;
    end else begin
      c_base_s = {W{1'b0}};
    end

    if (c_base_s == {W{1'b1}}) begin
      c_next_s = c_base_s;
    end else begin
      c_next_s = c_base_s + W'(1);
    end

    dir_up_s = (target_proportion > prop_q);
    if (dir_up_s) begin
      stepped_s = prop_q + P'(1);
    end else begin
      stepped_s = prop_q - P'(1);
    end
  end

  // Next-state logic; everything holds between frame_start pulses except fade_done
  always_comb begin
    state_d = state_q;
    prop_d  = prop_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (frame_start) begin
      case (state_q)
        IDLE: begin
          if (target_proportion == prop_q) begin
            cnt_d = {W{1'b0}};
          end else if (jump) begin
            prop_d = target_proportion;
            cnt_d  = {W{1'b0}};
            done_d = 1'b1;
          end else if (c_next_s >= eff_fps_s) begin
            prop_d = stepped_s;
            cnt_d  = {W{1'b0}};
            if (stepped_s == target_proportion) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FADING;
            end
          end else begin
            cnt_d   = c_next_s;
            state_d = FADING;
          end
        end
        FADING: begin
          if (jump) begin
            prop_d  = target_proportion;
            cnt_d   = {W{1'b0}};
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (target_proportion == prop_q) begin
            cnt_d   = {W{1'b0}};
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (c_next_s >= eff_fps_s) begin
            prop_d = stepped_s;
            cnt_d  = {W{1'b0}};
            if (stepped_s == target_proportion) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FADING;
            end
          end else begin
            cnt_d = c_next_s;
          end
        end
        default: begin
          state_d = IDLE;
          prop_d  = {P{1'b0}};
          cnt_d   = {W{1'b0}};
          done_d  = 1'b0;
        end
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any fade without a completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prop_q  <= {P{1'b0}};
      cnt_q   <= {W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prop_q  <= prop_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign src_a_proportion = prop_q;
  assign fading           = (state_q == FADING);
  assign fade_done        = done_q;

endmodule

// File: tb/tb_transparency_fade_controller.sv
// Directed bench for transparency_fade_controller with hand-computed expectations.
module tb_transparency_fade_controller;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic [2:0] target_proportion;
  logic [7:0] frames_per_step;
  logic       jump;
  logic [2:0] src_a_proportion;
  logic       fading;
  logic       fade_done;

  int n_cmp = 0;
  int n_err = 0;

  transparency_fade_controller #(
    .TRANSPARENCY_PRECISION(3),
    .FRAME_DIV_WIDTH(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .target_proportion(target_proportion),
    .frames_per_step  (frames_per_step),
    .jump             (jump),
    .src_a_proportion (src_a_proportion),
    .fading           (fading),
    .fade_done        (fade_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int p, input int f, input int d);
    chk({tag, ".prop"}, {29'd0, src_a_proportion}, p);
    chk({tag, ".fading"}, {31'd0, fading}, f);
    chk({tag, ".done"}, {31'd0, fade_done}, d);
  endtask

  // One frame_start pulse; returns at the falling edge after the capturing edge
  task automatic pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    target_proportion = 3'd0;
    frames_per_step = 8'd1;
    jump = 1'b0;
    repeat (2) @(negedge clk);
    chk3("reset", 0, 0, 0);
    rst = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      pulse();
      chk3($sformatf("hold0_%0d", i), 0, 0, 0);
    end

    target_proportion = 3'd5;
    for (int i = 1; i <= 5; i++) begin
      pulse();
      chk3($sformatf("up5_%0d", i), i, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    @(negedge clk);
    chk("up5_done_clear", {31'd0, fade_done}, 0);

    target_proportion = 3'd2;
    frames_per_step = 8'd3;
    for (int i = 1; i <= 9; i++) begin
      pulse();
      chk3($sformatf("down2_%0d", i), 5 - (i / 3), (i < 9) ? 1 : 0, (i == 9) ? 1 : 0);
    end

    frames_per_step = 8'd0;
    target_proportion = 3'd4;
    pulse();
    chk3("fps0_1", 3, 1, 0);
    pulse();
    chk3("fps0_2", 4, 0, 1);

    frames_per_step = 8'd1;
    target_proportion = 3'd0;
    jump = 1'b1;
    pulse();
    chk3("jump0", 0, 0, 1);
    jump = 1'b0;
    target_proportion = 3'd7;
    for (int i = 1; i <= 3; i++) begin
      pulse();
      chk3($sformatf("up7_%0d", i), i, 1, 0);
    end
    target_proportion = 3'd1;
    pulse();
    chk3("redir_1", 2, 1, 0);
    pulse();
    chk3("redir_2", 1, 0, 1);

    target_proportion = 3'd5;
    pulse();
    chk3("oncur_1", 2, 1, 0);
    target_proportion = 3'd2;
    pulse();
    chk3("oncur_2", 2, 0, 1);

    target_proportion = 3'd0;
    jump = 1'b1;
    pulse();
    chk3("jumpz", 0, 0, 1);
    target_proportion = 3'd6;
    pulse();
    chk3("jump6", 6, 0, 1);
    @(negedge clk);
    chk3("jump6_after", 6, 0, 0);
    jump = 1'b0;
    target_proportion = 3'd3;
    repeat (3) @(negedge clk);
    chk3("nopulse", 6, 0, 0);

    target_proportion = 3'd0;
    jump = 1'b1;
    pulse();
    chk3("jumpz2", 0, 0, 1);
    jump = 1'b0;
    target_proportion = 3'd7;
    for (int i = 1; i <= 4; i++) begin
      pulse();
      chk3($sformatf("pre_rst_%0d", i), i, 1, 0);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk3("async_rst", 0, 0, 0);
    @(negedge clk);
    chk3("rst_held", 0, 0, 0);
    rst = 1'b0;
    pulse();
    chk3("resume", 1, 1, 0);

    // Lowering frames_per_step below the running count steps on the next pulse
    frames_per_step = 8'd5;
    pulse();
    chk3("slow_1", 1, 1, 0);
    pulse();
    chk3("slow_2", 1, 1, 0);
    frames_per_step = 8'd1;
    pulse();
    chk3("lowered", 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/transparency_fade_controller.md
Name: transparency_fade_controller

Overview:
- Generates the `src_a_proportion` value consumed by the per-channel transparency blend stages.
- Ramps the proportion one LSB at a time toward a commanded target, at a programmable rate in frames per step.
- Updates only on frame boundaries, so a blend never changes mid-frame and cannot tear.
- Sits between the control-register block (target, rate, jump) and the pixel pipeline blend stages.

Parameters:
- TRANSPARENCY_PRECISION, 3, width of the proportion. Maximum value is 2^P-1, so 100% src_a is never produced.
- FRAME_DIV_WIDTH, 8, width of the frames-per-step setting and of the internal frame counter.

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle pulse from video timing at the start of vertical blank.
- target_proportion  in  TRANSPARENCY_PRECISION  commanded src_a proportion. Sampled only on frame_start cycles.
- frames_per_step  in  FRAME_DIV_WIDTH  frame_start pulses per one-LSB step. Value 0 is treated as 1. Compared live.
- jump  in  1  level. When high on a frame_start cycle, load target immediately instead of ramping.
- src_a_proportion  out  TRANSPARENCY_PRECISION  registered proportion fed to the blend stages.
- fading  out  1  high while in state FADING.
- fade_done  out  1  one-cycle pulse when the proportion reaches the target.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. Reset values: src_a_proportion=0, fading=0, fade_done=0, frame counter=0, state=IDLE. Asserting rst mid-fade aborts the fade immediately (asynchronously); no fade_done is issued.
- All state changes happen only on cycles where frame_start=1. Between pulses, every register holds except fade_done, which is cleared.
- Outputs are registered. A change decided on a frame_start cycle is visible on the next clock edge (latency 1).
- eff_fps = (frames_per_step==0) ? 1 : frames_per_step.
- Direction: up if target > current, down if target < current. Re-evaluated on every frame_start. A target change mid-fade redirects the ramp without restarting the counter.
- Steps are exactly ±1 and never overshoot. Arithmetic is unsigned, and the value is bounded to [0, 2^P-1] by construction.
- States: IDLE and FADING. fading = (state==FADING).
- IDLE, frame_start, target==current: no change.
- IDLE, frame_start, jump=1, target!=current: load target, pulse fade_done, counter=0, stay IDLE.
- IDLE, frame_start, jump=0, target!=current: enter FADING and apply the FADING counting rule with counter starting at 0. With eff_fps=1, the first step happens on this same frame_start.
- FADING, frame_start, jump=1: load target, counter=0, go to IDLE, pulse fade_done.
- FADING, frame_start, target==current (target moved onto the current value): go to IDLE, pulse fade_done, counter=0, no step.
- FADING, frame_start, otherwise: c_next = counter+1.
  - If c_next >= eff_fps: step toward target and set counter=0. If the stepped value equals target, go to IDLE and pulse fade_done the same edge.
  - Else counter=c_next.
- Counter saturates rather than wrapping. If frames_per_step is lowered below the current count, the step occurs on the next frame_start.
- fade_done is high for exactly one cycle per completion, and never in the same cycle as rst.
- target_proportion and frames_per_step changes with no frame_start have no effect until the next pulse.

Test Plan:
- Reset with P=3: outputs 0/0/0. Hold target=0 and apply 5 frame_start pulses -> proportion stays 0, fading stays 0, no fade_done.
- target=5, fps=1, jump=0, 5 pulses -> proportion 1,2,3,4,5 after pulses 1–5. fading goes high after pulse 1 and low after pulse 5. fade_done is pulsed once, after pulse 5.
- Proportion=5, target=2, fps=3 -> steps to 4, 3, 2 after pulses 3, 6 and 9 respectively. fade_done follows pulse 9. fps=0 behaves exactly like fps=1.
- Mid-fade redirect: ramping 0→7 at fps=1 and at value 3, target changed to 1 -> next pulses give 2, then 1, then IDLE with fade_done. Changing target to the current value -> IDLE plus fade_done on the next pulse with no step.
- jump=1, target=6 from 0 -> proportion=6 one cycle after the pulse, with a single fade_done and fading never asserted. target change without a pulse -> no output change.
- Assert rst asynchronously (between clock edges) at proportion 4 mid-fade -> outputs 0 immediately with no fade_done. After release, fading resumes from 0 on the next pulse.
